fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage WISC-SP22 pipeline, directly upstream of the instruction decoder/control unit. It owns the PC, issues reads to a multi-cycle instruction memory through a request/done handshake, and presents one instruction per cycle in the IF/ID slot. It absorbs downstream stalls with a one-entry skid buffer, squashes in-flight fetches on branch/jump redirects, and stops issuing fetches after it captures a HALT.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, value driven on `instr_out` when the slot is invalid (opcode 00001).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect  in  1  branch/jump taken; resolved downstream.
- redirect_pc  in  16  redirect target.
- stall_id  in  1  decode cannot accept; hold the IF/ID slot.
- imem_rd  out  1  read request; held until `imem_done`.
- imem_addr  out  16  read address; stable while `imem_rd` is high.
- imem_done  in  1  read completes this cycle; `imem_data` is valid.
- imem_data  in  16  fetched instruction.
- imem_err  in  1  memory error; qualified by `imem_done`.
- instr_out  out  16  IF/ID instruction.
- pc_plus2_out  out  16  address of the fetched instruction + 2, modulo 2^16.
- valid_out  out  1  IF/ID slot holds a real instruction.
- halted  out  1  fetch has stopped on HALT or error.
- err  out  1  sticky fetch error.

## Operation
- States:
  - FETCH: `imem_rd`=1, `imem_addr`=pc.
  - WAIT: request held, miss in progress.
  - SQUASH: request held; the returning data will be discarded.
  - SKID: output full and stalled; one instruction is buffered; no request.
  - HALTED: no request.
- Deliver event: `imem_done` in FETCH or WAIT with no redirect that cycle.
  - pc ← pc+2.
  - If slot free (`!valid_out || !stall_id`): load `instr_out`/`pc_plus2_out`, `valid_out`←1.
  - Otherwise load the skid buffer and go to SKID.
  - Next state is HALTED if `imem_data[15:11]`==00000, otherwise FETCH.
  - A HALT that lands in the skid buffer moves to HALTED when it drains.
- FETCH with no `imem_done` → WAIT. WAIT with no `imem_done` → stays in WAIT.
- Slot consumed (`valid_out && !stall_id`) with no new delivery → `valid_out`←0, `instr_out`←NOP_INSTR.
- SKID with `!stall_id` → skid moves to the output slot (valid) → FETCH or HALTED.
- Redirect (priority over everything except rst):
  - `valid_out`←0 and the skid buffer is cleared.
  - FETCH/WAIT with `imem_done` that cycle: data dropped, pc←`redirect_pc`, → FETCH.
  - FETCH/WAIT without `imem_done`: latch `redirect_pc` as pending, → SQUASH.
  - SQUASH: pending target is overwritten by the newest redirect.
  - SKID or HALTED: pc←`redirect_pc`, → FETCH; `halted` clears.
- SQUASH with `imem_done`: data discarded, pc←pending target, → FETCH.
- Error:
  - Sources: `imem_err` with `imem_done` in FETCH/WAIT, or a `redirect_pc[0]`=1 accepted as the new pc.
  - Effect: `err`←1 (sticky until rst), `valid_out`←0, → HALTED.
  - A redirect does not leave HALTED when `err`=1.
- Reset values:
  - pc=RESET_PC, state=FETCH, `valid_out`=0, `instr_out`=NOP_INSTR, `pc_plus2_out`=0, `halted`=0, `err`=0, skid empty.
  - `imem_rd` is forced to 0 while rst is high.
- `imem_rd` = state∈{FETCH,WAIT,SQUASH} && !rst.
- `imem_addr` = pc in FETCH/WAIT, the squashed address in SQUASH, otherwise pc.
- `halted` = state==HALTED.

## Timing
- Hit (`imem_done` in the same cycle as the FETCH request): `valid_out` rises the next cycle; sustained throughput is 1 instruction/cycle.
- Miss completing N cycles after the request: instruction is valid N+1 cycles after the request; `imem_rd`/`imem_addr` stay stable throughout.
- Redirect on cycle t: `valid_out`=0 at t+1. The first request to the target:
  - issues at t+1 if no read is outstanding;
  - issues the cycle after the squashed `imem_done` otherwise.
- Skid drains one cycle after `stall_id` falls; no instruction is lost or duplicated.
- PC wrap: 16'hFFFE + 2 = 16'h0000, no error.

## Structure
- Shared package `wisc_pkg`:
  - fetch state enum;
  - `OP_HALT` = 5'b00000;
  - `NOP_INSTR` default = 16'h0800;
  - opcode field slice constants (bits [15:11]).
- Sub-module `reg16`: 16-bit register with write enable and synchronous reset value. Instantiated for pc, the output slot, and the skid buffer.

## Test plan
- Reset, memory answers every request with `imem_done` in the same cycle, data 0x4000,0x4001,…: `valid_out` first high the cycle after the first request; consecutive cycles show `pc_plus2_out` = 0x0002, 0x0004, 0x0006…
- Miss of 3 cycles on pc=0x0010: `imem_addr` held at 0x0010 for 4 cycles; one valid instruction with `pc_plus2_out`=0x0012.
- `stall_id` high for 4 cycles while hits continue: one instruction enters the skid, no request while in SKID; after release the order is exact and nothing is dropped.
- Redirect to 0x0100 during a miss at 0x0020:
  - squashed data never appears on the output;
  - the next `imem_addr` is 0x0100;
  - a second redirect to 0x0200 during SQUASH wins.
- Fetch 0x0000 (HALT) at 0x0040: `halted`=1, `imem_rd`=0 from then on. A later redirect to 0x0050 resumes fetch at 0x0050.
- `imem_err` with `imem_done`: `err`=1, `halted`=1, `valid_out`=0. A redirect is ignored, and rst clears `err`.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-SP22 pipeline front end.
package wisc_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0]  OP_HALT       = 5'b00000;
  localparam logic [DATA_W-1:0] NOP_INSTR_DEF = 16'h0800;

  // Fetch-stage control states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SQUASH = 3'd2,
    ST_SKID   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  // True when the opcode field of an instruction encodes HALT
  function automatic logic is_halt(input logic [DATA_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/reg16.sv
// 16-bit register with load enable and synchronous reset value.
module reg16
  import wisc_pkg::*;
#(
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Hold unless enabled; reset to the configured value
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a multi-cycle imem handshake,
// fills the IF/ID slot with a one-entry skid buffer behind it.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              stall_id,
  output logic              imem_rd,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_done,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_err,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] pc_plus2_out,
  output logic              valid_out,
  output logic              halted,
  output logic              err
);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] pc_d;
  logic              pc_en;

  logic [DATA_W-1:0] slot_instr_d;
  logic [DATA_W-1:0] slot_pc2_d;
  logic              slot_en;

  logic [DATA_W-1:0] skid_instr;
  logic [DATA_W-1:0] skid_pc2;
  logic [DATA_W-1:0] skid_instr_d;
  logic [DATA_W-1:0] skid_pc2_d;
  logic              skid_en;
  logic              skid_load;

  logic [DATA_W-1:0] pend_pc;
  logic              pend_en;

  logic [DATA_W-1:0] new_pc;
  logic              take_new;

  logic              valid_nxt;
  logic              err_nxt;
  logic              rd_q;
  logic              slot_free;
  logic              consume;

  assign pc_inc    = pc + DATA_W'(2);
  assign slot_free = !valid_out || !stall_id;
  assign consume   = valid_out && !stall_id;

  // A redirect empties the skid; otherwise it captures a stalled delivery
  assign skid_en      = skid_load || redirect;
  assign skid_instr_d = redirect ? '0 : imem_data;
  assign skid_pc2_d   = redirect ? '0 : pc_inc;

  reg16 #(.RST_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc)
  );

  reg16 #(.RST_VAL(NOP_INSTR)) u_slot_instr (
    .clk (clk),
    .rst (rst),
    .en  (slot_en),
    .d   (slot_instr_d),
    .q   (instr_out)
  );

  reg16 #(.RST_VAL(16'h0000)) u_slot_pc2 (
    .clk (clk),
    .rst (rst),
    .en  (slot_en),
    .d   (slot_pc2_d),
    .q   (pc_plus2_out)
  );

  reg16 #(.RST_VAL(16'h0000)) u_skid_instr (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (skid_instr_d),
    .q   (skid_instr)
  );

  reg16 #(.RST_VAL(16'h0000)) u_skid_pc2 (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (skid_pc2_d),
    .q   (skid_pc2)
  );

  // Next-state and datapath load decisions; redirect outranks everything
  always_comb begin
    state_nxt    = state;
    valid_nxt    = valid_out;
    err_nxt      = err;
    pc_en        = 1'b0;
    pc_d         = pc_inc;
    slot_en      = 1'b0;
    slot_instr_d = NOP_INSTR;
    slot_pc2_d   = pc_plus2_out;
    skid_load    = 1'b0;
    pend_en      = 1'b0;
    take_new     = 1'b0;
    new_pc       = redirect_pc;

    if (redirect) begin
      valid_nxt = 1'b0;
      slot_en   = 1'b1;
      case (state)
        ST_FETCH, ST_WAIT, ST_SQUASH: begin
          // With data returning now the read is simply dropped; otherwise
          // the outstanding read must be absorbed first.
          if (imem_done) begin
            take_new = 1'b1;
          end else begin
            pend_en   = 1'b1;
            state_nxt = ST_SQUASH;
          end
        end
        ST_SKID:   take_new  = 1'b1;
        ST_HALTED: take_new  = !err;
        default:   state_nxt = ST_HALTED;
      endcase
    end else begin
      if (consume) begin
        valid_nxt = 1'b0;
        slot_en   = 1'b1;
      end
      case (state)
        ST_FETCH, ST_WAIT: begin
          if (imem_done) begin
            if (imem_err) begin
              err_nxt   = 1'b1;
              valid_nxt = 1'b0;
              slot_en   = 1'b1;
              state_nxt = ST_HALTED;
            end else begin
              pc_en = 1'b1;
              if (slot_free) begin
                slot_en      = 1'b1;
                slot_instr_d = imem_data;
                slot_pc2_d   = pc_inc;
                valid_nxt    = 1'b1;
                state_nxt    = is_halt(imem_data) ? ST_HALTED : ST_FETCH;
              end else begin
                skid_load = 1'b1;
                state_nxt = ST_SKID;
              end
            end
          end else begin
            state_nxt = ST_WAIT;
          end
        end
        ST_SQUASH: begin
          if (imem_done) begin
            take_new = 1'b1;
            new_pc   = pend_pc;
          end
        end
        ST_SKID: begin
          // A buffered HALT only takes effect once it reaches the slot
          if (!stall_id) begin
            slot_en      = 1'b1;
            slot_instr_d = skid_instr;
            slot_pc2_d   = skid_pc2;
            valid_nxt    = 1'b1;
            state_nxt    = is_halt(skid_instr) ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: state_nxt = ST_HALTED;
        default:   state_nxt = ST_HALTED;
      endcase
    end

    // Adopting a new PC; a misaligned target is a fetch error
    if (take_new) begin
      pc_en = 1'b1;
      pc_d  = new_pc;
      if (new_pc[0]) begin
        err_nxt      = 1'b1;
        valid_nxt    = 1'b0;
        slot_en      = 1'b1;
        slot_instr_d = NOP_INSTR;
        state_nxt    = ST_HALTED;
      end else begin
        state_nxt = ST_FETCH;
      end
    end
  end

  // Control state, status flags and the pending redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      valid_out <= 1'b0;
      err       <= 1'b0;
      halted    <= 1'b0;
      rd_q      <= 1'b1;
      pend_pc   <= RESET_PC;
    end else begin
      state     <= state_nxt;
      valid_out <= valid_nxt;
      err       <= err_nxt;
      halted    <= (state_nxt == ST_HALTED);
      rd_q      <= (state_nxt inside {ST_FETCH, ST_WAIT, ST_SQUASH});
      if (pend_en) begin
        pend_pc <= redirect_pc;
      end
    end
  end

  // PC is not updated during SQUASH, so it still names the squashed read
  assign imem_rd   = rd_q && !rst;
  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory model
// and an in-order scoreboard on the IF/ID slot.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        stall_id = 1'b0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_done = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_err = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2_out;
  logic        valid_out;
  logic        halted;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  int          lat = 0;
  int          wait_cnt = 0;
  logic [15:0] halt_addr = 16'hFFFF;
  logic [15:0] err_addr  = 16'hFFFF;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall_id     (stall_id),
    .imem_rd      (imem_rd),
    .imem_addr    (imem_addr),
    .imem_done    (imem_done),
    .imem_data    (imem_data),
    .imem_err     (imem_err),
    .instr_out    (instr_out),
    .pc_plus2_out (pc_plus2_out),
    .valid_out    (valid_out),
    .halted       (halted),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Memory contents: HALT at halt_addr, otherwise 0x4000 + word index
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    return 16'h4000 + (a >> 1);
  endfunction

  // Memory model: answers after 'lat' cycles of a held request
  always @(posedge clk) begin
    #2;
    if (imem_rd) begin
      if (wait_cnt >= lat) begin
        imem_done = 1'b1;
        imem_data = mem_word(imem_addr);
        imem_err  = (imem_addr == err_addr);
        wait_cnt  = 0;
      end else begin
        imem_done = 1'b0;
        imem_err  = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      imem_done = 1'b0;
      imem_err  = 1'b0;
      wait_cnt  = 0;
    end
  end

  // Scoreboard monitor: every consumed slot must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_out && !stall_id) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got instr=%h pc2=%h, required no instruction",
                 instr_out, pc_plus2_out);
      end else begin
        e = exp_q.pop_front();
        if (instr_out !== e.instr || pc_plus2_out !== e.pc2) begin
          n_errors++;
          $display("FAIL sb_order: got instr=%h pc2=%h, required instr=%h pc2=%h",
                   instr_out, pc_plus2_out, e.instr, e.pc2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc2);
    exp_t e;
    e.instr = instr;
    e.pc2   = pc2;
    exp_q.push_back(e);
  endtask

  task automatic do_redirect(input logic [15:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect = 1'b0;
  endtask

  // Bounded wait for halted, then let the monitor take the last slot
  task automatic wait_halt(input string name);
    for (int i = 0; i < 60; i++) begin
      if (halted) break;
      tick();
    end
    chk1(name, halted, 1'b1);
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset state
    halt_addr = 16'h0010;
    lat       = 0;
    tick();
    tick();
    chk1("rst_valid", valid_out, 1'b0);
    chk16("rst_instr", instr_out, 16'h0800);
    chk16("rst_pc2", pc_plus2_out, 16'h0000);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_rd", imem_rd, 1'b0);
    chk16("rst_addr", imem_addr, 16'h0000);

    // Back-to-back hits from reset, ending on a HALT at 0x0010
    for (int i = 0; i < 8; i++) push(16'h4000 + 16'(i), 16'(2 * i + 2));
    push(16'h0000, 16'h0012);
    rst = 1'b0;
    #2;
    chk1("hit_req", imem_rd, 1'b1);
    chk1("hit_valid_early", valid_out, 1'b0);
    tick();
    chk1("hit_valid", valid_out, 1'b1);
    chk16("hit_pc2_first", pc_plus2_out, 16'h0002);
    tick();
    chk16("hit_pc2_second", pc_plus2_out, 16'h0004);
    wait_halt("hit_halt");

    // Three-cycle miss at 0x0010
    lat       = 3;
    halt_addr = 16'h0012;
    push(16'h4008, 16'h0012);
    push(16'h0000, 16'h0014);
    do_redirect(16'h0010);
    chk1("miss_halted_clr", halted, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk16("miss_addr_hold", imem_addr, 16'h0010);
      chk1("miss_rd_hold", imem_rd, 1'b1);
      chk1("miss_valid_low", valid_out, 1'b0);
      if (i < 3) tick();
    end
    tick();
    chk1("miss_valid", valid_out, 1'b1);
    chk16("miss_pc2", pc_plus2_out, 16'h0012);
    wait_halt("miss_halt");

    // Four-cycle stall with hits continuing behind it
    lat       = 0;
    halt_addr = 16'h0090;
    for (int i = 0; i < 8; i++) push(16'h4040 + 16'(i), 16'h0082 + 16'(2 * i));
    push(16'h0000, 16'h0092);
    do_redirect(16'h0080);
    tick();
    stall_id = 1'b1;
    chk16("stall_first", instr_out, 16'h4040);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("skid_no_req", imem_rd, 1'b0);
      chk16("skid_hold", instr_out, 16'h4040);
    end
    stall_id = 1'b0;
    tick();
    chk16("skid_drain", instr_out, 16'h4041);
    chk1("skid_drain_valid", valid_out, 1'b1);
    chk16("skid_resume_addr", imem_addr, 16'h0084);
    wait_halt("stall_halt");

    // Redirect during a miss, overridden by a second redirect in SQUASH
    lat       = 3;
    halt_addr = 16'h0202;
    push(16'h4100, 16'h0202);
    push(16'h0000, 16'h0204);
    do_redirect(16'h0020);
    tick();
    chk16("sq_miss_addr", imem_addr, 16'h0020);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    chk16("sq_addr_held", imem_addr, 16'h0020);
    chk1("sq_valid_low", valid_out, 1'b0);
    redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    chk1("sq_rd_held", imem_rd, 1'b1);
    chk16("sq_addr_held2", imem_addr, 16'h0020);
    tick();
    chk16("sq_new_addr", imem_addr, 16'h0200);
    chk1("sq_new_rd", imem_rd, 1'b1);
    chk1("sq_valid_after", valid_out, 1'b0);
    wait_halt("sq_halt");

    // HALT at 0x0040, then resume at 0x0050
    lat       = 0;
    halt_addr = 16'h0040;
    push(16'h401E, 16'h003E);
    push(16'h401F, 16'h0040);
    push(16'h0000, 16'h0042);
    do_redirect(16'h003C);
    wait_halt("halt_0040");
    for (int i = 0; i < 3; i++) begin
      chk1("halt_no_req", imem_rd, 1'b0);
      tick();
    end
    halt_addr = 16'h0052;
    push(16'h4028, 16'h0052);
    push(16'h0000, 16'h0054);
    do_redirect(16'h0050);
    chk1("resume_halted", halted, 1'b0);
    chk1("resume_rd", imem_rd, 1'b1);
    chk16("resume_addr", imem_addr, 16'h0050);
    wait_halt("resume_halt");

    // PC wrap across 0xFFFE
    halt_addr = 16'h0002;
    push(16'hBFFE, 16'hFFFE);
    push(16'hBFFF, 16'h0000);
    push(16'h4000, 16'h0002);
    push(16'h0000, 16'h0004);
    do_redirect(16'hFFFC);
    chk16("wrap_addr", imem_addr, 16'hFFFC);
    wait_halt("wrap_halt");
    chk1("wrap_no_err", err, 1'b0);

    // Memory error at 0x0064
    halt_addr = 16'hFFFF;
    err_addr  = 16'h0064;
    push(16'h4030, 16'h0062);
    push(16'h4031, 16'h0064);
    do_redirect(16'h0060);
    wait_halt("err_halt");
    chk1("err_set", err, 1'b1);
    chk1("err_valid", valid_out, 1'b0);
    do_redirect(16'h0100);
    chk1("err_redir_halted", halted, 1'b1);
    chk1("err_redir_rd", imem_rd, 1'b0);
    chk1("err_sticky", err, 1'b1);
    tick();
    chk1("err_redir_rd2", imem_rd, 1'b0);

    // Reset clears the error
    err_addr  = 16'hFFFF;
    halt_addr = 16'h0000;
    push(16'h0000, 16'h0002);
    rst = 1'b1;
    tick();
    tick();
    chk1("rst_err_clr", err, 1'b0);
    chk1("rst_halted_clr", halted, 1'b0);
    rst = 1'b0;
    wait_halt("rst_halt");

    // Misaligned redirect target is an error
    do_redirect(16'h0071);
    chk1("odd_err", err, 1'b1);
    chk1("odd_halted", halted, 1'b1);
    chk1("odd_rd", imem_rd, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
